pawn_move_scanner: RTL and testbench

- Sequential, parametrised successor to the single-cycle pawn move generator.
- On `start`, captures a snapshot of the side-to-move's piece locations and a board occupancy/colour map, then evaluates one pawn per clock.
- Per pawn it reports single push, double push, left capture, right capture and promotion.
- Feeds the move-list builder; handshakes with the search controller through start/busy/done.

---
 rtl/pawn_move_scanner_if.sv | 32 +++
 rtl/pawn_move_scanner.sv | 115 +++++++++++
 tb/tb_pawn_move_scanner.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pawn_move_scanner_if.sv
// Handshake and board-snapshot bus between the search controller
// (master) and the pawn move scanner (slave).
interface pawn_move_scanner_if #(
  parameter int BOARD_DIM  = 8,
  parameter int NUM_PIECES = 16,
  parameter int NUM_PAWNS  = 8,
  parameter int MOVE_W     = 5
);
  localparam int COORD_W = $clog2(BOARD_DIM);
  localparam int CNT_W   = $clog2(NUM_PAWNS*4+1);

  logic                              start;
  logic                              player;
  logic [NUM_PIECES*2*COORD_W-1:0]   locationVector;
  logic [NUM_PIECES-1:0]             aliveVector;
  logic [BOARD_DIM*BOARD_DIM-1:0]    occupiedBoard;
  logic [BOARD_DIM*BOARD_DIM-1:0]    colourBoard;
  logic                              busy;
  logic                              done;
  logic [NUM_PAWNS*MOVE_W-1:0]       moveSet;
  logic [CNT_W-1:0]                  moveCount;

  modport master (
    output start, player, locationVector, aliveVector, occupiedBoard, colourBoard,
    input  busy, done, moveSet, moveCount
  );

  modport slave (
    input  start, player, locationVector, aliveVector, occupiedBoard, colourBoard,
    output busy, done, moveSet, moveCount
  );
endinterface

// File: rtl/pawn_move_scanner.sv
// Sequential pawn move scanner: snapshots the position on start, then
// evaluates one pawn per clock into its moveSet slot and accumulates
// the total number of push/capture moves.
module pawn_move_scanner #(
  parameter int BOARD_DIM  = 8,
  parameter int COORD_W    = $clog2(BOARD_DIM),
  parameter int NUM_PIECES = 16,
  parameter int NUM_PAWNS  = 8,
  parameter int MOVE_W     = 5
) (
  input  logic                clock,
  input  logic                reset,
  pawn_move_scanner_if.slave  bus
);
  localparam int CNT_W  = $clog2(NUM_PAWNS*4+1);
  localparam int IDX_W  = (NUM_PAWNS > 1) ? $clog2(NUM_PAWNS) : 1;
  localparam int PLOC_W = NUM_PAWNS*2*COORD_W;
  localparam int SQ_N   = BOARD_DIM*BOARD_DIM;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                  state;
  logic [IDX_W-1:0]            idx;
  logic                        s_player;
  logic [PLOC_W-1:0]           s_loc;     // only pawn slots are ever evaluated
  logic [NUM_PAWNS-1:0]        s_alive;
  logic [SQ_N-1:0]             s_occ;
  logic [SQ_N-1:0]             s_col;
  logic [NUM_PAWNS*MOVE_W-1:0] move_set;
  logic [CNT_W-1:0]            move_count;

  assign bus.busy      = (state == SCAN);
  assign bus.done      = (state == DONE);
  assign bus.moveSet   = move_set;
  assign bus.moveCount = move_count;

  logic [COORD_W-1:0]        rank, file, fr, f2, file_l, file_r;
  logic [COORD_W-1:0]        start_rank, promo_rank;
  logic signed [COORD_W:0]   step, fwd_r, fwd2_r;
  logic                      alive, fwd_ok, fwd2_ok;
  logic                      push1, push2, cap_l, cap_r, promo;
  logic [MOVE_W-1:0]         result;
  logic [2:0]                n_moves;

  // Evaluate the pawn at idx from the snapshot. A negative signed rank
  // means off-board: stepping past the last rank overflows to -BOARD_DIM,
  // and stepping below rank 0 gives -1, so the sign bit alone suffices.
  always_comb begin
    {file, rank} = s_loc[idx*2*COORD_W +: 2*COORD_W];
    alive      = s_alive[idx];
    step       = s_player ? {{COORD_W{1'b0}}, 1'b1} : {(COORD_W+1){1'b1}};
    fwd_r      = $signed({1'b0, rank}) + step;
    fwd2_r     = fwd_r + step;
    fwd_ok     = !fwd_r[COORD_W];
    fwd2_ok    = !fwd2_r[COORD_W];
    fr         = fwd_r[COORD_W-1:0];
    f2         = fwd2_r[COORD_W-1:0];
    file_l     = file - 1'b1;
    file_r     = file + 1'b1;
    start_rank = s_player ? COORD_W'(1) : COORD_W'(BOARD_DIM-2);
    promo_rank = s_player ? COORD_W'(BOARD_DIM-1) : '0;
    // BOARD_DIM is a power of two, so {rank,file} is rank*BOARD_DIM+file
    push1   = fwd_ok && !s_occ[{fr, file}];
    push2   = push1 && (rank == start_rank) && fwd2_ok && !s_occ[{f2, file}];
    cap_l   = fwd_ok && (file != '0) && s_occ[{fr, file_l}] &&
              (s_col[{fr, file_l}] != s_player);
    cap_r   = fwd_ok && (file != '1) && s_occ[{fr, file_r}] &&
              (s_col[{fr, file_r}] != s_player);
    promo   = fwd_ok && (fr == promo_rank) && (push1 || cap_l || cap_r);
    result  = alive ? MOVE_W'({push1, push2, cap_l, cap_r, promo}) : '0;
    n_moves = alive ? (3'(push1) + 3'(push2) + 3'(cap_l) + 3'(cap_r)) : 3'd0;
  end

  // Control FSM: snapshot on an accepted start, one pawn per SCAN cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      s_player   <= 1'b0;
      s_loc      <= '0;
      s_alive    <= '0;
      s_occ      <= '0;
      s_col      <= '0;
      move_set   <= '0;
      move_count <= '0;
    end else begin
      case (state)
        SCAN: begin
          move_set[idx*MOVE_W +: MOVE_W] <= result;
          move_count <= move_count + CNT_W'(n_moves);
          if (idx == IDX_W'(NUM_PAWNS-1)) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            state      <= SCAN;
            idx        <= '0;
            s_player   <= bus.player;
            s_loc      <= bus.locationVector[PLOC_W-1:0];
            s_alive    <= bus.aliveVector[NUM_PAWNS-1:0];
            s_occ      <= bus.occupiedBoard;
            s_col      <= bus.colourBoard;
            move_set   <= '0;
            move_count <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pawn_move_scanner.sv
// Self-checking bench for pawn_move_scanner: a board-level reference
// model is checked every cycle, plus literal expectations for the
// directed positions.
module tb_pawn_move_scanner;
  localparam int BD  = 8;
  localparam int NP  = 16;
  localparam int NPW = 8;
  localparam int MW  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pawn_move_scanner_if #(.BOARD_DIM(BD), .NUM_PIECES(NP), .NUM_PAWNS(NPW), .MOVE_W(MW)) bus();

  pawn_move_scanner #(.BOARD_DIM(BD), .NUM_PIECES(NP), .NUM_PAWNS(NPW), .MOVE_W(MW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_state = 0;   // 0 idle, 1 scanning, 2 done
  int           m_written = 0;
  logic         m_pl = 0;
  logic [95:0]  m_loc = '0;
  logic [15:0]  m_alive = '0;
  logic [63:0]  m_occ = '0, m_col = '0;
  logic [4:0]   m_slot [NPW];

  function automatic logic [4:0] eval_pawn(int k);
    int r, f, d, fr;
    bit p1, p2, cl, cr, pr;
    if (!m_alive[k]) return 5'b0;
    r  = int'(m_loc[k*6 +: 3]);
    f  = int'(m_loc[k*6+3 +: 3]);
    d  = m_pl ? 1 : -1;
    fr = r + d;
    if (fr < 0 || fr >= BD) return 5'b0;
    p1 = !m_occ[fr*BD+f];
    p2 = p1 && (r == (m_pl ? 1 : BD-2)) && !m_occ[(fr+d)*BD+f];
    cl = (f > 0)    && m_occ[fr*BD+f-1] && (m_col[fr*BD+f-1] != m_pl);
    cr = (f < BD-1) && m_occ[fr*BD+f+1] && (m_col[fr*BD+f+1] != m_pl);
    pr = (fr == (m_pl ? BD-1 : 0)) && (p1 || cl || cr);
    return {p1, p2, cl, cr, pr};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_written = 0;
    end else if (m_state == 1) begin
      m_written++;
      if (m_written == NPW) m_state = 2;
    end else if (bus.start) begin
      m_pl = bus.player; m_loc = bus.locationVector; m_alive = bus.aliveVector;
      m_occ = bus.occupiedBoard; m_col = bus.colourBoard;
      for (int k = 0; k < NPW; k++) m_slot[k] = eval_pawn(k);
      m_written = 0; m_state = 1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      logic [39:0] es;
      int ec;
      es = '0; ec = 0;
      for (int k = 0; k < m_written; k++) begin
        es[k*MW +: MW] = m_slot[k];
        ec += $countones(m_slot[k][4:1]);
      end
      chk("busy",      bus.busy,      m_state == 1);
      chk("done",      bus.done,      m_state == 2);
      chk("moveSet",   bus.moveSet,   es);
      chk("moveCount", bus.moveCount, ec);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic        t_pl;
  logic [95:0] t_loc;
  logic [15:0] t_alive;
  logic [63:0] t_occ, t_col;

  task automatic clear_pos();
    t_pl = 1; t_loc = '0; t_alive = '0; t_occ = '0; t_col = '0;
  endtask

  task automatic put_piece(input int k, input int r, input int f);
    t_loc[k*6 +: 6] = {3'(f), 3'(r)};
  endtask

  task automatic occupy(input int r, input int f, input bit white);
    t_occ[r*BD+f] = 1'b1; t_col[r*BD+f] = white;
  endtask

  task automatic init_position(input bit pl);
    clear_pos();
    t_pl = pl; t_alive = 16'hFFFF;
    for (int f = 0; f < BD; f++) begin
      occupy(0, f, 1); occupy(1, f, 1); occupy(6, f, 0); occupy(7, f, 0);
      put_piece(f,     pl ? 1 : 6, f);
      put_piece(8 + f, pl ? 0 : 7, f);
    end
  endtask

  task automatic apply();
    bus.player = t_pl; bus.locationVector = t_loc; bus.aliveVector = t_alive;
    bus.occupiedBoard = t_occ; bus.colourBoard = t_col;
  endtask

  // Returns 2 time units after the start edge.
  task automatic start_scan();
    @(posedge clock); #2;
    apply(); bus.start = 1'b1;
    @(posedge clock); #2;
    bus.start = 1'b0;
  endtask

  // lat0 = edges already elapsed since the start edge (start edge counts as 1).
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    repeat (40) begin
      if (bus.done) break;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.start = 0; clear_pos(); apply();
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_set",  bus.moveSet, 0);
    chk("reset_cnt",  bus.moveCount, 0);
    cmp_en = 1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    // initial position, white then black
    for (int p = 1; p >= 0; p--) begin
      init_position(p[0]);
      start_scan();
      wait_done(1, lat);
      chk("init_latency", lat, 9);
      chk("init_set", bus.moveSet, {8{5'b11000}});
      chk("init_cnt", bus.moveCount, 16);
    end

    // edge-file capture, blocked push
    clear_pos(); t_alive = 16'h0001;
    put_piece(0, 4, 0); occupy(4, 0, 1); occupy(5, 1, 0); occupy(5, 0, 1);
    start_scan(); wait_done(1, lat);
    chk("edge_set", bus.moveSet, 40'h2);
    chk("edge_cnt", bus.moveCount, 1);

    // promotion with and without capture
    for (int w = 0; w < 2; w++) begin
      clear_pos(); t_alive = 16'h0001;
      put_piece(0, 6, 3); occupy(6, 3, 1); occupy(7, 4, w[0]);
      start_scan(); wait_done(1, lat);
      chk("promo_set", bus.moveSet, w ? 40'h11 : 40'h13);
      chk("promo_cnt", bus.moveCount, w ? 1 : 2);
    end

    // dead pawn 0, start and input changes during scan
    init_position(1); t_alive = 16'h00FE;
    start_scan();
    repeat (3) begin @(posedge clock); #2; end
    bus.player = 0; bus.occupiedBoard = '1; bus.aliveVector = '1; bus.start = 1;
    @(posedge clock); #2 bus.start = 0;
    wait_done(5, lat);
    chk("dead_latency", lat, 9);
    chk("dead_set", bus.moveSet, {{7{5'b11000}}, 5'b00000});
    chk("dead_cnt", bus.moveCount, 14);

    // start coincident with the completing edge is ignored
    init_position(1);
    start_scan();
    repeat (7) begin @(posedge clock); #2; end
    bus.start = 1;
    @(posedge clock); #2 bus.start = 0;
    chk("late_start_done", bus.done, 1);
    chk("late_start_busy", bus.busy, 0);
    repeat (3) begin @(posedge clock); #2; end
    chk("hold_set", bus.moveSet, {8{5'b11000}});
    // start from DONE is accepted and clears results
    init_position(0);
    start_scan();
    chk("restart_busy", bus.busy, 1);
    chk("restart_set",  bus.moveSet, 0);
    wait_done(1, lat);
    chk("restart_latency", lat, 9);

    // reset in the middle of a scan
    init_position(1);
    start_scan();
    repeat (3) begin @(posedge clock); #2; end
    reset = 1'b0; #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_set",  bus.moveSet, 0);
    chk("abort_cnt",  bus.moveCount, 0);
    @(posedge clock); #2 reset = 1'b1;
    start_scan(); wait_done(1, lat);
    chk("post_abort_latency", lat, 9);
    chk("post_abort_set", bus.moveSet, {8{5'b11000}});

    // randomized positions with input noise and stray starts during scan
    for (int it = 0; it < 60; it++) begin
      t_pl = 1'($urandom);
      t_loc = {$urandom, $urandom, $urandom};
      t_alive = 16'($urandom);
      t_occ = (it % 2) ? {$urandom, $urandom} : ({$urandom, $urandom} & {$urandom, $urandom});
      t_col = {$urandom, $urandom};
      start_scan();
      for (int c = 0; c < 40 && !bus.done; c++) begin
        @(posedge clock); #2;
        if ($urandom_range(3) == 0) begin
          bus.player = 1'($urandom);
          bus.occupiedBoard = {$urandom, $urandom};
          bus.locationVector = {$urandom, $urandom, $urandom};
        end
        bus.start = ($urandom_range(3) == 0);
      end
      bus.start = 0;
      chk("rand_done", bus.done, 1);
      repeat ($urandom_range(2)) @(posedge clock);
    end

    @(negedge clock);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
